phase_modulate_pipe: RTL and testbench

Pipelined, multi-voice successor to the combinational phase modulator. It computes one modulated tuning word per accepted sample: tuning_word + tuning_word × mod_signal × scalar[voice].
- Voices are time-multiplexed through a single 3-stage datapath.
- Each voice has its own scalar, held in a register file.
- Valid/ready handshake with full-pipeline stall.
- Selectable saturating or wrapping output, with a per-sample overflow flag.
Sits between the voice sequencer and the per-voice phase accumulators.

---
 rtl/synth_pkg.sv | 18 +
 rtl/pm_scalar_regfile.sv | 45 ++++
 rtl/phase_modulate_pipe.sv | 148 ++++++++++++++
 tb/tb_phase_modulate_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : synth_pkg
//  Description : Shared constants and helpers for the phase modulation pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int SCALAR_W    = 8;
    localparam int SCALAR_FRAC = 4;
    localparam logic [SCALAR_W-1:0] SCALAR_ONE = 8'h10;

    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pm_scalar_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : pm_scalar_regfile
//  Description : Per-voice Q4.4 modulation index registers, sync write,
//                async read, out-of-range addresses read as unity.
//  Revision    : 1.0 - initial release
// ============================================================================
module pm_scalar_regfile
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int AW         = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [SCALAR_W-1:0] i_wdata,
    input  logic [AW-1:0]       i_raddr,
    output logic [SCALAR_W-1:0] o_rdata
);

    localparam logic [AW:0] c_NV = (AW+1)'(NUM_VOICES);

    logic [SCALAR_W-1:0] r_mem [NUM_VOICES];
    logic                w_wr_ok;
    logic                w_rd_ok;

    assign w_wr_ok = ({1'b0, i_waddr} < c_NV);
    assign w_rd_ok = ({1'b0, i_raddr} < c_NV);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_mem[v] <= SCALAR_ONE;
            end
        end else if (i_we && w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_ok ? r_mem[i_raddr] : SCALAR_ONE;

endmodule
`default_nettype wire

// File: rtl/phase_modulate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : phase_modulate_pipe
//  Description : 3-stage multi-voice phase modulator:
//                tw + tw * mod * scalar[voice], with stall-on-backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_modulate_pipe
    import synth_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter int WI         = 2,
    parameter int WF         = 16,
    parameter int NUM_VOICES = 8,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [clog2_safe(NUM_VOICES)-1:0]  in_voice,
    input  logic [NUM_BITS-1:0]                tuning_word,
    input  logic [WI+WF-1:0]                   mod_signal,
    input  logic                               scalar_we,
    input  logic [clog2_safe(NUM_VOICES)-1:0]  scalar_addr,
    input  logic [SCALAR_W-1:0]                scalar_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [clog2_safe(NUM_VOICES)-1:0]  out_voice,
    output logic [NUM_BITS-1:0]                modulated_tuning_word,
    output logic                               ovf
);

    localparam int c_AW  = clog2_safe(NUM_VOICES);
    localparam int c_MW  = WI + WF;
    localparam int c_P0W = NUM_BITS + 1 + c_MW;
    localparam int c_D0W = NUM_BITS + WI + 1;
    localparam int c_P1W = c_D0W + SCALAR_W + 1;
    localparam int c_D1W = NUM_BITS + WI + 6;
    localparam int c_SW  = c_D1W + 1;

    logic                       w_ce;
    logic [SCALAR_W-1:0]        w_scalar;
    logic signed [c_P0W-1:0]    w_p0;
    logic signed [c_D0W-1:0]    w_d0;
    logic signed [c_P1W-1:0]    w_p1;
    logic signed [c_D1W-1:0]    w_d1;
    logic signed [c_SW-1:0]     w_s;
    logic                       w_neg;
    logic                       w_hi;
    logic                       w_ovf;
    logic [NUM_BITS-1:0]        w_res;

    logic                       r1_valid;
    logic [c_AW-1:0]            r1_voice;
    logic [NUM_BITS-1:0]        r1_tw;
    logic [SCALAR_W-1:0]        r1_scalar;
    logic signed [c_D0W-1:0]    r1_d0;

    logic                       r2_valid;
    logic [c_AW-1:0]            r2_voice;
    logic [NUM_BITS-1:0]        r2_tw;
    logic signed [c_D1W-1:0]    r2_d1;

    logic                       r_out_valid;
    logic [c_AW-1:0]            r_out_voice;
    logic [NUM_BITS-1:0]        r_out_word;
    logic                       r_ovf;

    // A stalled output freezes every stage; bubbles are never squeezed out.
    assign w_ce     = ~r_out_valid | out_ready;
    assign in_ready = w_ce;

    pm_scalar_regfile #(
        .NUM_VOICES (NUM_VOICES),
        .AW         (c_AW)
    ) u_scalar_rf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (scalar_we),
        .i_waddr (scalar_addr),
        .i_wdata (scalar_data),
        .i_raddr (in_voice),
        .o_rdata (w_scalar)
    );

    assign w_p0 = c_P0W'($signed({1'b0, tuning_word})) * c_P0W'($signed(mod_signal));
    assign w_d0 = c_D0W'(w_p0 >>> WF);

    assign w_p1 = c_P1W'(r1_d0) * c_P1W'($signed({1'b0, r1_scalar}));
    assign w_d1 = c_D1W'(w_p1 >>> SCALAR_FRAC);

    assign w_s   = c_SW'($signed({1'b0, r2_tw})) + c_SW'(r2_d1);
    assign w_neg = w_s[c_SW-1];
    assign w_hi  = ~w_neg & (|w_s[c_SW-2:NUM_BITS]);
    assign w_ovf = w_neg | w_hi;

    if (SATURATE) begin : g_sat
        assign w_res = w_neg ? '0 : (w_hi ? '1 : w_s[NUM_BITS-1:0]);
    end else begin : g_wrap
        assign w_res = w_s[NUM_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r1_voice    <= '0;
            r1_tw       <= '0;
            r1_scalar   <= '0;
            r1_d0       <= '0;
            r2_valid    <= 1'b0;
            r2_voice    <= '0;
            r2_tw       <= '0;
            r2_d1       <= '0;
            r_out_valid <= 1'b0;
            r_out_voice <= '0;
            r_out_word  <= '0;
            r_ovf       <= 1'b0;
        end else if (w_ce) begin
            r1_valid    <= in_valid;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
            if (in_valid) begin
                r1_voice  <= in_voice;
                r1_tw     <= tuning_word;
                r1_scalar <= w_scalar;
                r1_d0     <= w_d0;
            end
            if (r1_valid) begin
                r2_voice <= r1_voice;
                r2_tw    <= r1_tw;
                r2_d1    <= w_d1;
            end
            if (r2_valid) begin
                r_out_voice <= r2_voice;
                r_out_word  <= w_res;
                r_ovf       <= w_ovf;
            end
        end
    end

    assign out_valid             = r_out_valid;
    assign out_voice             = r_out_voice;
    assign modulated_tuning_word = r_out_word;
    assign ovf                   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_phase_modulate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_modulate_pipe
//  Description : Scoreboard bench for phase_modulate_pipe, saturating and
//                wrapping instances driven in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_modulate_pipe;

    typedef struct packed {
        logic [2:0]  voice;
        logic [31:0] word;
        logic        ovf;
        logic [31:0] wword;
        logic        wovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_voice = '0;
    logic [31:0] tuning_word = '0;
    logic [17:0] mod_signal = '0;
    logic        scalar_we = 1'b0;
    logic [2:0]  scalar_addr = '0;
    logic [7:0]  scalar_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_voice;
    logic [31:0] modulated_tuning_word;
    logic        ovf;

    logic        wr_in_ready;
    logic        wr_out_valid;
    logic [2:0]  wr_out_voice;
    logic [31:0] wr_word;
    logic        wr_ovf;

    res_t exp_q[$];
    res_t got_q[$];
    logic [7:0] sc_model [8];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    phase_modulate_pipe #(
        .NUM_BITS(32), .WI(2), .WF(16), .NUM_VOICES(8), .SATURATE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_voice(in_voice), .tuning_word(tuning_word), .mod_signal(mod_signal),
        .scalar_we(scalar_we), .scalar_addr(scalar_addr), .scalar_data(scalar_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_voice(out_voice),
        .modulated_tuning_word(modulated_tuning_word), .ovf(ovf)
    );

    phase_modulate_pipe #(
        .NUM_BITS(32), .WI(2), .WF(16), .NUM_VOICES(8), .SATURATE(1'b0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(wr_in_ready),
        .in_voice(in_voice), .tuning_word(tuning_word), .mod_signal(mod_signal),
        .scalar_we(scalar_we), .scalar_addr(scalar_addr), .scalar_data(scalar_data),
        .out_valid(wr_out_valid), .out_ready(out_ready), .out_voice(wr_out_voice),
        .modulated_tuning_word(wr_word), .ovf(wr_ovf)
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            got_q.push_back(res_t'{out_voice, modulated_tuning_word, ovf, wr_word, wr_ovf});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic res_t model(input logic [2:0] v, input logic [31:0] tw, input logic [17:0] m);
        longint p0, d0, p1, d1, s;
        res_t r;
        p0 = longint'(tw) * longint'($signed(m));
        d0 = p0 >>> 16;
        p1 = d0 * longint'(sc_model[v]);
        d1 = p1 >>> 4;
        s  = longint'(tw) + d1;
        r.voice = v;
        r.ovf   = (s < 0) || (s > 64'sh0000_0000_FFFF_FFFF);
        r.word  = (s < 0) ? 32'h0 : (r.ovf ? 32'hFFFF_FFFF : s[31:0]);
        r.wword = s[31:0];
        r.wovf  = r.ovf;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [2:0] v, input logic [31:0] tw,
                                input logic [17:0] m, input res_t e);
        logic acc;
        int   guard;
        step();
        in_valid = 1'b1; in_voice = v; tuning_word = tw; mod_signal = m;
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL accept: sample voice %0d not accepted within 50 cycles", v);
        end else begin
            exp_q.push_back(e);
        end
    endtask

    task automatic check_results(input string name);
        int   g;
        res_t e, r;
        g = 0;
        while (got_q.size() < exp_q.size() && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d results, expected %0d", name, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            r = got_q.pop_front();
            n_tests++;
            if (r !== e) begin
                n_fail++;
                $display("FAIL %s_result: got voice=%0d word=%h ovf=%b wrap=%h wovf=%b, expected voice=%0d word=%h ovf=%b wrap=%h wovf=%b",
                         name, r.voice, r.word, r.ovf, r.wword, r.wovf,
                         e.voice, e.word, e.ovf, e.wword, e.wovf);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || wr_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b/%b, expected 0/0", out_valid, wr_out_valid);
        end
        n_tests++;
        if (out_voice !== 3'd0 || wr_out_voice !== 3'd0 || modulated_tuning_word !== 32'h0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: got voice=%0d word=%h ovf=%b, expected 0/0/0",
                               out_voice, modulated_tuning_word, ovf);
        end
        n_tests++;
        if (in_ready !== 1'b1 || wr_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b/%b, expected 1/1", in_ready, wr_in_ready);
        end
        for (int i = 0; i < 8; i++) sc_model[i] = 8'h10;
    endtask

    task automatic test_basic(input logic [2:0] v);
        drive_sample(v, 32'h0100_0000, 18'h08000, res_t'{v, 32'h0180_0000, 1'b0, 32'h0180_0000, 1'b0});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== (k == 3)) begin
                n_fail++; $display("FAIL latency_c%0d: out_valid got %b, expected %b", k, out_valid, (k == 3));
            end
        end
        check_results("basic");
    endtask

    task automatic test_negative();
        drive_sample(3'd0, 32'h0100_0000, 18'h30000, res_t'{3'd0, 32'h0, 1'b0, 32'h0, 1'b0});
        drive_sample(3'd0, 32'h3, 18'h38000, res_t'{3'd0, 32'h1, 1'b0, 32'h1, 1'b0});
        drive_sample(3'd0, 32'h100, 18'h20000, res_t'{3'd0, 32'h0, 1'b1, 32'hFFFF_FF00, 1'b1});
        drive_sample(3'd0, 32'hFFFF_FFFF, 18'h20000, res_t'{3'd0, 32'h0, 1'b1, 32'h1, 1'b1});
        drive_sample(3'd0, 32'h0, 18'h1FFFF, res_t'{3'd0, 32'h0, 1'b0, 32'h0, 1'b0});
        check_results("negative");
    endtask

    task automatic test_overflow();
        step();
        scalar_we = 1'b1; scalar_addr = 3'd2; scalar_data = 8'h20;
        step();
        scalar_we = 1'b0;
        sc_model[2] = 8'h20;
        drive_sample(3'd2, 32'hC000_0000, 18'h10000, res_t'{3'd2, 32'hFFFF_FFFF, 1'b1, 32'h4000_0000, 1'b1});
        check_results("overflow");
    endtask

    task automatic test_collision();
        step();
        scalar_we = 1'b1; scalar_addr = 3'd1; scalar_data = 8'h00;
        in_valid = 1'b1; in_voice = 3'd1; tuning_word = 32'h1000; mod_signal = 18'h10000;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL collision_ready: in_ready got %b, expected 1", in_ready);
        end
        step();
        exp_q.push_back(res_t'{3'd1, 32'h2000, 1'b0, 32'h2000, 1'b0});
        scalar_we = 1'b0; in_valid = 1'b0;
        sc_model[1] = 8'h00;
        drive_sample(3'd1, 32'h1000, 18'h10000, res_t'{3'd1, 32'h1000, 1'b0, 32'h1000, 1'b0});
        check_results("collision");
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] tws  [6] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h7FFF_0000, 32'h0000_FFFF, 32'hF000_0001, 32'h1234_0000};
        logic [17:0] mods [6] = '{18'h04000, 18'h3C000, 18'h0FFFF, 18'h20000, 18'h00001, 18'h2ABCD};
        logic [31:0] held;
        logic        acc;
        int i, c;
        i = 0; c = 0; held = '0;
        step();
        while (i < 6 && c < 60) begin
            out_ready = !(c >= 3 && c < 7);
            in_valid = 1'b1; in_voice = 3'(i); tuning_word = tws[i]; mod_signal = mods[i];
            @(negedge clk);
            if (c >= 3 && c < 7) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL stall_in_ready_c%0d: got %b, expected 0", c, in_ready);
                end
                if (c == 3) held = modulated_tuning_word;
                else begin
                    n_tests++;
                    if (modulated_tuning_word !== held) begin
                        n_fail++; $display("FAIL stall_hold_c%0d: got %h, expected %h", c, modulated_tuning_word, held);
                    end
                end
            end
            acc = in_ready;
            step();
            if (acc) begin
                exp_q.push_back(model(3'(i), tws[i], mods[i]));
                i++;
            end
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_results("stall");
    endtask

    task automatic test_reset_midflight();
        step();
        in_valid = 1'b1; in_voice = 3'd4; tuning_word = 32'h0100_0000; mod_signal = 18'h08000;
        repeat (3) step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL midreset_valid_c%0d: got %b, expected 0", k, out_valid);
            end
        end
        n_tests++;
        if (got_q.size() != 0 || modulated_tuning_word !== 32'h0) begin
            n_fail++; $display("FAIL midreset_flush: got %0d results word=%h, expected 0 results word=0",
                               got_q.size(), modulated_tuning_word);
        end
        got_q.delete();
        for (int v = 0; v < 8; v++) sc_model[v] = 8'h10;
        test_basic(3'd3);
        drive_sample(3'd2, 32'hC000_0000, 18'h10000, res_t'{3'd2, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1});
        drive_sample(3'd1, 32'h1000, 18'h10000, res_t'{3'd1, 32'h2000, 1'b0, 32'h2000, 1'b0});
        check_results("midreset_scalars");
    endtask

    initial begin
        test_reset();
        test_basic(3'd0);
        test_negative();
        test_overflow();
        test_collision();
        test_back_to_back_stall();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
